// File: rtl/tau_seq_pkg.sv
// Shared types for the microcode sequencer: FSM state encoding and stack fault codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package tau_seq_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        PC_UPDATE = 3'd4,
        HALTED    = 3'd5,
        FAULT     = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE = 2'b00,
        FAULT_OVF  = 2'b01,
        FAULT_UNF  = 2'b10
    } fault_code_t;

endpackage

// File: rtl/micro_return_stack.sv
// Micro-subroutine return address LIFO, DEPTH entries of WIDTH bits.
// Latency: push/pop take effect at the next clock edge; data_out shows the top entry combinationally.
// Backpressure: full/empty are flags only; push when full or pop when empty is ignored (caller faults instead).
//
// Ports: clock, reset (async, active high), clear (sync, empties the stack),
//        push/pop (never both in one cycle), data_in, data_out (top of stack),
//        full, empty.
module micro_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    // Pointer counts 0..DEPTH, so it needs one more code than the entry index.
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    sp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign wr_idx   = AW'(sp);
    assign top_idx  = AW'(sp - PW'(1));
    assign data_out = mem[top_idx];
    assign full     = (sp == PW'(DEPTH));
    assign empty    = (sp == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    // Storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge clock) begin
        if (push && !full && !clear) begin
            mem[wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/microcode_sequencer_n.sv
// Instruction sequencer: fetch, decode/dispatch, microcode execution with branch/call/return, PC update.
// Latency: FETCH 1 cycle, DECODE 1 cycle, EXECUTE until instr_finish, PC_UPDATE 1 cycle.
// Backpressure: enable low freezes state, uaddr and stack, and forces all strobes inactive.
//
// Ports: clock, reset (async, active high), enable, halt_opcode, dispatch_address,
//        microcode controls (instr_finish, jump_flag, ucall, uret, ubranch,
//        branch_target, cond_sel, cond_polarity), flags;
//        outputs uaddr (registered), urom_read_enable, pc_enable, pc_load_n (active low),
//        halted, fault, fault_code, state_out.
module microcode_sequencer_n
    import tau_seq_pkg::*;
#(
    parameter int UADDR_WIDTH    = 16,
    parameter int FLAG_WIDTH     = 8,
    parameter int STACK_DEPTH    = 4,
    parameter int COND_SEL_WIDTH = $clog2(FLAG_WIDTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      halt_opcode,
    input  logic [UADDR_WIDTH-1:0]    dispatch_address,
    input  logic                      instr_finish,
    input  logic                      jump_flag,
    input  logic                      ucall,
    input  logic                      uret,
    input  logic                      ubranch,
    input  logic [UADDR_WIDTH-1:0]    branch_target,
    input  logic [COND_SEL_WIDTH-1:0] cond_sel,
    input  logic                      cond_polarity,
    input  logic [FLAG_WIDTH-1:0]     flags,
    output logic [UADDR_WIDTH-1:0]    uaddr,
    output logic                      urom_read_enable,
    output logic                      pc_enable,
    output logic                      pc_load_n,
    output logic                      halted,
    output logic                      fault,
    output logic [1:0]                fault_code,
    output logic [STATE_WIDTH-1:0]    state_out
);

    seq_state_t             state_q, state_d;
    logic [UADDR_WIDTH-1:0] uaddr_q, uaddr_d;
    logic                   jump_q, jump_d;
    fault_code_t            fault_code_q, fault_code_d;

    logic                   stk_clear, stk_push, stk_pop;
    logic                   stk_full, stk_empty;
    logic [UADDR_WIDTH-1:0] stk_top;
    logic [UADDR_WIDTH-1:0] uaddr_inc;
    logic                   flag_bit;
    logic                   branch_taken;

    assign uaddr_inc = uaddr_q + UADDR_WIDTH'(1);

    // A select beyond the flag vector reads as a cleared flag.
    always_comb begin
        flag_bit = 1'b0;
        if (int'(cond_sel) < FLAG_WIDTH) begin
            flag_bit = flags[cond_sel];
        end
    end

    assign branch_taken = (flag_bit == cond_polarity);

    micro_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (UADDR_WIDTH)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop      (stk_pop),
        .data_in  (uaddr_inc),
        .data_out (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            uaddr_q      <= '0;
            jump_q       <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            uaddr_q      <= uaddr_d;
            jump_q       <= jump_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        uaddr_d      = uaddr_q;
        jump_d       = jump_q;
        fault_code_d = fault_code_q;
        stk_clear    = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: state_d = DECODE;
                DECODE: begin
                    if (halt_opcode) begin
                        state_d = HALTED;
                    end else begin
                        uaddr_d   = dispatch_address;
                        stk_clear = 1'b1;
                        state_d   = EXECUTE;
                    end
                end
                EXECUTE: begin
                    // Priority chain: finish > return > call > branch > increment.
                    if (instr_finish) begin
                        jump_d  = jump_flag;
                        state_d = PC_UPDATE;
                    end else if (uret) begin
                        if (stk_empty) begin
                            fault_code_d = FAULT_UNF;
                            state_d      = FAULT;
                        end else begin
                            stk_pop = 1'b1;
                            uaddr_d = stk_top;
                        end
                    end else if (ucall) begin
                        if (stk_full) begin
                            fault_code_d = FAULT_OVF;
                            state_d      = FAULT;
                        end else begin
                            stk_push = 1'b1;
                            uaddr_d  = branch_target;
                        end
                    end else if (ubranch && branch_taken) begin
                        uaddr_d = branch_target;
                    end else begin
                        uaddr_d = uaddr_inc;
                    end
                end
                PC_UPDATE: state_d = FETCH;
                default: ; // HALTED and FAULT are left only through reset
            endcase
        end
    end

    // Strobes come straight from registered state and the latched jump bit,
    // gated only by enable, so each is one clean cycle wide.
    assign urom_read_enable = enable && (state_q == EXECUTE);
    assign pc_enable        = enable && (state_q == PC_UPDATE) && !jump_q;
    assign pc_load_n        = !(enable && (state_q == PC_UPDATE) && jump_q);
    assign halted           = (state_q == HALTED);
    assign fault            = (state_q == FAULT);
    assign fault_code       = fault_code_q;
    assign state_out        = state_q;
    assign uaddr            = uaddr_q;

endmodule

// File: tb/tb_microcode_sequencer_n.sv
// Self-checking bench for microcode_sequencer_n: directed vectors, hand sequences, randomized model check.
// Latency: n/a.
// Backpressure: n/a.
module tb_microcode_sequencer_n;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        halt_opcode;
    logic [15:0] dispatch_address;
    logic        instr_finish;
    logic        jump_flag;
    logic        ucall;
    logic        uret;
    logic        ubranch;
    logic [15:0] branch_target;
    logic [2:0]  cond_sel;
    logic        cond_polarity;
    logic [7:0]  flags;
    logic [15:0] uaddr;
    logic        urom_read_enable;
    logic        pc_enable;
    logic        pc_load_n;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [2:0]  state_out;

    microcode_sequencer_n #(
        .UADDR_WIDTH (16),
        .FLAG_WIDTH  (8),
        .STACK_DEPTH (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .halt_opcode      (halt_opcode),
        .dispatch_address (dispatch_address),
        .instr_finish     (instr_finish),
        .jump_flag        (jump_flag),
        .ucall            (ucall),
        .uret             (uret),
        .ubranch          (ubranch),
        .branch_target    (branch_target),
        .cond_sel         (cond_sel),
        .cond_polarity    (cond_polarity),
        .flags            (flags),
        .uaddr            (uaddr),
        .urom_read_enable (urom_read_enable),
        .pc_enable        (pc_enable),
        .pc_load_n        (pc_load_n),
        .halted           (halted),
        .fault            (fault),
        .fault_code       (fault_code),
        .state_out        (state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] start;
        logic        fin;
        logic        ret;
        logic        call;
        logic        br;
        logic [15:0] tgt;
        logic [2:0]  sel;
        logic        pol;
        logic [7:0]  flg;
        logic [15:0] exp_ua;
        logic [2:0]  exp_st;
        logic [1:0]  exp_fc;
    } vec_t;

    vec_t vecs [10];

    // Reference model state, in the terms of the state_out codes.
    int          m_st;
    int          m_ua;
    bit          m_jmp;
    int          m_fc;
    int          m_stk [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        halt_opcode   = 1'b0;
        instr_finish  = 1'b0;
        jump_flag     = 1'b0;
        ucall         = 1'b0;
        uret          = 1'b0;
        ubranch       = 1'b0;
        branch_target = 16'h0000;
        cond_sel      = 3'd0;
        cond_polarity = 1'b0;
        flags         = 8'h00;
    endtask

    // Called one time unit after a rising edge; the pulse ends well before the next edge.
    task automatic do_reset();
        clear_ctl();
        enable           = 1'b0;
        dispatch_address = 16'h0000;
        reset            = 1'b1;
        #2;
        reset            = 1'b0;
    endtask

    task automatic go_exec(input logic [15:0] addr);
        dispatch_address = addr;
        enable           = 1'b1;
        step();   // FETCH
        step();   // DECODE
        step();   // EXECUTE, uaddr = addr
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_ua  = 0;
        m_jmp = 1'b0;
        m_fc  = 0;
        m_stk.delete();
    endtask

    initial begin
        vecs[0] = '{16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00, 16'h0041, 3'd3, 2'd0};
        vecs[1] = '{16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 3'd2, 1'b1, 8'h04, 16'h0100, 3'd3, 2'd0};
        vecs[2] = '{16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 3'd2, 1'b0, 8'h04, 16'h0041, 3'd3, 2'd0};
        vecs[3] = '{16'h0040, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 3'd2, 1'b0, 8'h04, 16'h0200, 3'd3, 2'd0};
        vecs[4] = '{16'h0060, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00, 16'h0060, 3'd6, 2'd2};
        vecs[5] = '{16'h0080, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0300, 3'd0, 1'b0, 8'h00, 16'h0080, 3'd4, 2'd0};
        vecs[6] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00, 16'h0000, 3'd3, 2'd0};
        vecs[7] = '{16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123, 3'd5, 1'b0, 8'h00, 16'h0123, 3'd3, 2'd0};
        vecs[8] = '{16'h0060, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0222, 3'd0, 1'b0, 8'h00, 16'h0060, 3'd6, 2'd2};
        vecs[9] = '{16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123, 3'd7, 1'b1, 8'h7F, 16'h0041, 3'd3, 2'd0};

        // ---- Reset values ----
        clear_ctl();
        enable           = 1'b0;
        dispatch_address = 16'h0000;
        reset            = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_state", state_out, 0);
        chk("rst_uaddr", uaddr, 0);
        chk("rst_outs", {urom_read_enable, pc_enable, pc_load_n, halted, fault, fault_code}, 7'b0010000);
        reset = 1'b0;
        step();

        // ---- Reset then run ----
        enable           = 1'b1;
        dispatch_address = 16'h0040;
        step(); chk("run_fetch", state_out, 1);
        step(); chk("run_decode", state_out, 2);
        step(); chk("run_exec", state_out, 3);
        chk("run_ua0", uaddr, 16'h0040);
        chk("run_urom", urom_read_enable, 1);
        step(); chk("run_ua1", uaddr, 16'h0041);
        step(); chk("run_ua2", uaddr, 16'h0042);

        // ---- PC strobes ----
        instr_finish = 1'b1; jump_flag = 1'b0;
        step();
        instr_finish = 1'b0;
        chk("pcinc_state", state_out, 4);
        chk("pcinc_strobes", {pc_enable, pc_load_n}, 2'b11);
        step();
        chk("pcinc_after_state", state_out, 1);
        chk("pcinc_after_strobes", {pc_enable, pc_load_n}, 2'b01);
        step(); step();
        chk("pcld_exec", uaddr, 16'h0040);
        instr_finish = 1'b1; jump_flag = 1'b1;
        step();
        instr_finish = 1'b0; jump_flag = 1'b0;
        chk("pcld_strobes", {pc_enable, pc_load_n}, 2'b00);
        step();
        chk("pcld_after_strobes", {pc_enable, pc_load_n}, 2'b01);
        chk("pcld_after_state", state_out, 1);

        // ---- Single-cycle EXECUTE actions from a fresh dispatch ----
        for (int v = 0; v < 10; v++) begin
            do_reset();
            go_exec(vecs[v].start);
            instr_finish  = vecs[v].fin;
            uret          = vecs[v].ret;
            ucall         = vecs[v].call;
            ubranch       = vecs[v].br;
            branch_target = vecs[v].tgt;
            cond_sel      = vecs[v].sel;
            cond_polarity = vecs[v].pol;
            flags         = vecs[v].flg;
            step();
            clear_ctl();
            chk($sformatf("vec%0d_uaddr", v), uaddr, vecs[v].exp_ua);
            chk($sformatf("vec%0d_state", v), state_out, vecs[v].exp_st);
            chk($sformatf("vec%0d_fcode", v), fault_code, vecs[v].exp_fc);
        end

        // ---- Call/return and overflow ----
        do_reset();
        go_exec(16'h0050);
        ucall = 1'b1; branch_target = 16'h0200;
        step();
        clear_ctl();
        chk("call_uaddr", uaddr, 16'h0200);
        uret = 1'b1;
        step();
        clear_ctl();
        chk("ret_uaddr", uaddr, 16'h0051);
        // Call together with an untaken branch: the call must push a return address.
        ucall = 1'b1; ubranch = 1'b1; branch_target = 16'h0280; flags = 8'h00; cond_polarity = 1'b1;
        step();
        clear_ctl();
        chk("callbr_uaddr", uaddr, 16'h0280);
        uret = 1'b1;
        step();
        clear_ctl();
        chk("callbr_ret", uaddr, 16'h0052);
        for (int i = 0; i < 4; i++) begin
            ucall = 1'b1; branch_target = 16'h0300 + 16'(i);
            step();
            chk($sformatf("nest%0d_uaddr", i), uaddr, 16'h0300 + 16'(i));
        end
        branch_target = 16'h0400;
        step();
        clear_ctl();
        chk("ovf_state", state_out, 6);
        chk("ovf_fcode", fault_code, 2'b01);
        chk("ovf_fault", fault, 1);
        chk("ovf_uaddr", uaddr, 16'h0303);
        step();
        chk("ovf_sticky", state_out, 6);
        do_reset();
        chk("ovf_cleared", {fault, fault_code, state_out}, 6'b0);

        // ---- Halt ----
        enable           = 1'b1;
        dispatch_address = 16'h0010;
        halt_opcode      = 1'b1;
        step(); step();
        chk("halt_decode", {halted, state_out}, 4'b0010);
        step();
        chk("halt_entry", {halted, state_out}, 4'b1101);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_hold", {halted, state_out, urom_read_enable, pc_enable, pc_load_n}, 7'b1101001);
        end

        // ---- Freeze with enable low ----
        do_reset();
        go_exec(16'h0700);
        enable = 1'b0; ucall = 1'b1; branch_target = 16'h0900;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_uaddr", uaddr, 16'h0700);
            chk("frz_outs", {state_out, urom_read_enable}, 4'b0110);
        end
        clear_ctl();
        enable = 1'b1;
        uret = 1'b1;   // stack must still be empty: nothing was pushed while frozen
        step();
        clear_ctl();
        chk("frz_nopush", {state_out, fault_code}, 5'b11010);
        do_reset();
        go_exec(16'h0710);
        instr_finish = 1'b1;
        step();
        instr_finish = 1'b0;
        enable = 1'b0;
        #1 chk("frz_pc_strobe", {pc_enable, pc_load_n}, 2'b01);
        enable = 1'b1;
        #1 chk("unfrz_pc_strobe", {pc_enable, pc_load_n}, 2'b11);

        // ---- Asynchronous reset while the load strobe is active ----
        do_reset();
        go_exec(16'h1234);
        step();
        instr_finish = 1'b1; jump_flag = 1'b1;
        step();
        clear_ctl();
        chk("mid_pcld", pc_load_n, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_state", state_out, 0);
        chk("mid_rst_uaddr", uaddr, 0);
        chk("mid_rst_outs", {urom_read_enable, pc_enable, pc_load_n, halted, fault, fault_code}, 7'b0010000);
        reset = 1'b0;

        // ---- Randomized run against the reference model ----
        step();
        do_reset();
        model_reset();
        begin
            int term_cycles;
            int ns;
            int nua;
            bit njmp;
            int nfc;
            term_cycles = 0;
            for (int i = 0; i < 3000; i++) begin
                enable           = ($urandom_range(0, 9) != 0);
                halt_opcode      = ($urandom_range(0, 29) == 0);
                dispatch_address = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
                instr_finish     = ($urandom_range(0, 11) == 0);
                jump_flag        = 1'($urandom);
                uret             = ($urandom_range(0, 7) == 0);
                ucall            = ($urandom_range(0, 4) == 0);
                ubranch          = ($urandom_range(0, 2) == 0);
                branch_target    = 16'($urandom);
                cond_sel         = 3'($urandom);
                cond_polarity    = 1'($urandom);
                flags            = 8'($urandom);

                ns = m_st; nua = m_ua; njmp = m_jmp; nfc = m_fc;
                if (enable) begin
                    if (m_st == 0) ns = 1;
                    else if (m_st == 1) ns = 2;
                    else if (m_st == 2) begin
                        if (halt_opcode) ns = 5;
                        else begin
                            nua = dispatch_address;
                            m_stk.delete();
                            ns = 3;
                        end
                    end else if (m_st == 3) begin
                        if (instr_finish) begin
                            ns = 4; njmp = jump_flag;
                        end else if (uret) begin
                            if (m_stk.size() == 0) begin ns = 6; nfc = 2; end
                            else nua = m_stk.pop_back();
                        end else if (ucall) begin
                            if (m_stk.size() == 4) begin ns = 6; nfc = 1; end
                            else begin
                                m_stk.push_back((m_ua + 1) % 65536);
                                nua = branch_target;
                            end
                        end else if (ubranch && (((int'(flags) >> cond_sel) & 1) == int'(cond_polarity))) begin
                            nua = branch_target;
                        end else begin
                            nua = (m_ua + 1) % 65536;
                        end
                    end else if (m_st == 4) ns = 1;
                end

                step();
                m_st = ns; m_ua = nua; m_jmp = njmp; m_fc = nfc;

                chk("rnd_state", state_out, m_st);
                chk("rnd_uaddr", uaddr, m_ua);
                chk("rnd_fcode", fault_code, m_fc);
                chk("rnd_outs", {halted, fault, urom_read_enable, pc_enable, pc_load_n},
                    {m_st == 5, m_st == 6, enable && m_st == 3,
                     enable && m_st == 4 && !m_jmp, !(enable && m_st == 4 && m_jmp)});

                if (m_st == 5 || m_st == 6) term_cycles++;
                else term_cycles = 0;
                if (term_cycles > 6) begin
                    do_reset();
                    model_reset();
                    term_cycles = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer_n.md
Name: microcode_sequencer_n

Overview:
- Parametrised successor to the fixed execution driver and microcode sequencer counter pair.
- A single FSM sequences instruction fetch, decode/dispatch, microcode execution and PC update.
- The microcode address path is generalised: conditional micro-branches on ALU flags, micro-subroutine call/return through a parametrised LIFO, halt and fault states.
- Sits between the opcode translator ROM, the microcode ROM, the program counter and the ALU flags.

Parameters:
- UADDR_WIDTH, 16: microcode address width.
- FLAG_WIDTH, 8: ALU flag vector width.
- STACK_DEPTH, 4: micro-return stack entries (>=1).
- COND_SEL_WIDTH, $clog2(FLAG_WIDTH): width of the flag-select field.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run enable; low freezes the FSM and stack, and forces strobes low.
- halt_opcode  in  1  decoded instruction is HALT (from the halt check).
- dispatch_address  in  UADDR_WIDTH  microcode entry point from the opcode translator.
- instr_finish  in  1  microcode control: last micro-op of this instruction.
- jump_flag  in  1  microcode control: load PC instead of incrementing it.
- ucall  in  1  microcode control: call micro-subroutine.
- uret  in  1  microcode control: return from micro-subroutine.
- ubranch  in  1  microcode control: conditional micro-branch.
- branch_target  in  UADDR_WIDTH  call/branch destination.
- cond_sel  in  COND_SEL_WIDTH  flag bit tested by ubranch.
- cond_polarity  in  1  1 = branch if flag set; 0 = branch if flag clear.
- flags  in  FLAG_WIDTH  ALU flags.
- uaddr  out  UADDR_WIDTH  microcode ROM address (registered).
- urom_read_enable  out  1  microcode ROM read enable.
- pc_enable  out  1  PC increment strobe.
- pc_load_n  out  1  PC load strobe, active low.
- halted  out  1  in HALTED state.
- fault  out  1  sticky stack error.
- fault_code  out  2  01 = overflow, 10 = underflow, 00 = none.
- state_out  out  3  current FSM state, for debug.

Behaviour:
- **Reset** (async, any state, mid-instruction included):
  - state = IDLE, uaddr = 0, stack pointer = 0.
  - fault = 0, fault_code = 00, halted = 0.
  - urom_read_enable = 0, pc_enable = 0, pc_load_n = 1.
- **States:** IDLE(0), FETCH(1), DECODE(2), EXECUTE(3), PC_UPDATE(4), HALTED(5), FAULT(6).
- **enable = 0:** the FSM holds state, uaddr and stack. Strobes are forced inactive (pc_enable = 0, pc_load_n = 1, urom_read_enable = 0).
- **IDLE:** goes to FETCH on enable.
- **FETCH:** exactly 1 cycle (sync program RAM latency), then DECODE.
- **DECODE:**
  - If halt_opcode = 1, go to HALTED. halted = 1 from the next cycle.
  - Otherwise uaddr <= dispatch_address, stack pointer <= 0, then EXECUTE.
- **EXECUTE:**
  - urom_read_enable = 1.
  - Per cycle, one action applies, in strict priority order:
    1. instr_finish: go to PC_UPDATE; uaddr holds.
    2. uret: pop; uaddr <= popped value.
    3. ucall: push uaddr+1; uaddr <= branch_target.
    4. ubranch taken: uaddr <= branch_target. Taken means flags[cond_sel] == cond_polarity.
    5. Otherwise: uaddr <= uaddr+1.
  - Lower-priority controls asserted in the same cycle are ignored.
  - uaddr+1 wraps modulo 2^UADDR_WIDTH (0xFFFF -> 0x0000 by default); no fault.
  - A ucall with the stack full (STACK_DEPTH entries) is an overflow: go to FAULT, fault_code = 01, no push, uaddr holds.
  - A uret with the stack empty is an underflow: go to FAULT, fault_code = 10, uaddr holds.
  - cond_sel >= FLAG_WIDTH tests as 0.
- **PC_UPDATE:** exactly 1 cycle.
  - pc_load_n = 0 if jump_flag was 1 in the finishing cycle (latched); otherwise pc_enable = 1.
  - Never both.
  - Then FETCH.
- **Strobes:** pc_enable and pc_load_n are decoded from registered state and the latched jump bit; they are glitch-free and exactly 1 cycle wide.
- **HALTED, FAULT:** terminal; exit by reset only. Strobes inactive, urom_read_enable = 0. fault = 1 in FAULT.
- **Stack:** cleared on reset and on every dispatch in DECODE. Contents do not survive across instructions.

Decomposition:
- Package tau_seq_pkg holds:
  - seq_state_t enum with the encodings above;
  - fault_code_t (FAULT_NONE, FAULT_OVF, FAULT_UNF);
  - localparam STATE_WIDTH = 3.
- Sub-module micro_return_stack (parametrised LIFO).
  - Parameters: DEPTH, WIDTH.
  - Ports: clock, reset, clear, push, pop, data_in, data_out, full, empty.
  - Push and pop asserted together in the same cycle is illegal; the sequencer's priority order prevents it.

Test Plan:
- **Reset then run:** reset pulse, enable = 1, halt_opcode = 0, dispatch_address = 0x0040.
  - Expected states: IDLE -> FETCH -> DECODE -> EXECUTE.
  - uaddr = 0x0040, then 0x0041, 0x0042 on plain increments.
- **PC strobes:** instr_finish with jump_flag = 0 gives pc_enable = 1 for exactly 1 cycle, then FETCH.
  - Repeat with jump_flag = 1: pc_load_n = 0 for 1 cycle and pc_enable stays 0.
- **Micro-branch:**
  - flags = 0x04, cond_sel = 2, cond_polarity = 1, branch_target = 0x0100: uaddr becomes 0x0100.
  - Same with cond_polarity = 0: uaddr becomes uaddr+1.
  - ubranch and ucall asserted together: the call wins.
- **Call/return:**
  - ucall at uaddr 0x0050 to 0x0200: uaddr = 0x0200.
  - uret: uaddr = 0x0051.
  - Nest STACK_DEPTH = 4 calls, then a 5th ucall: FAULT, fault_code = 01, state_out = 6.
  - Reset clears the fault.
- **Underflow and wrap:**
  - uret on an empty stack: FAULT, fault_code = 10.
  - Separately, dispatch_address = 0xFFFF then an increment: uaddr = 0x0000 with no fault.
- **Halt, freeze, reset mid-op:**
  - halt_opcode = 1 in DECODE: halted = 1; strobes stay inactive for 20 cycles.
  - enable = 0 during EXECUTE: uaddr frozen.
  - Async reset asserted between clock edges: all outputs reach reset values before the next edge.
